// File: rtl/mem_ctrl.sv
// mem_ctrl: single-outstanding block memory controller arbitrating icache and dcache refills/writes
module mem_ctrl #(
    parameter int MEM_LATENCY      = 4,
    parameter int BLOCK_ADDR_WIDTH = 29,
    parameter int BLOCK_WIDTH      = 64
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        icache_req_valid,
    input  logic [BLOCK_ADDR_WIDTH-1:0] icache_req_block_addr,
    output logic                        icache_req_ready,
    input  logic                        icache_flush,
    output logic                        icache_resp_valid,
    output logic [BLOCK_WIDTH-1:0]      icache_resp_block_data,
    input  logic                        dcache_req_valid,
    input  logic                        dcache_req_type,
    input  logic [BLOCK_ADDR_WIDTH-1:0] dcache_req_block_addr,
    input  logic [BLOCK_WIDTH-1:0]      dcache_req_block_data,
    output logic                        dcache_req_ready,
    output logic                        dcache_resp_valid,
    output logic [BLOCK_WIDTH-1:0]      dcache_resp_block_data,
    output logic                        mem_en,
    output logic                        mem_we,
    output logic [BLOCK_ADDR_WIDTH-1:0] mem_addr,
    output logic [BLOCK_WIDTH-1:0]      mem_wdata,
    input  logic [BLOCK_WIDTH-1:0]      mem_rdata,
    output logic                        busy
);
    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
    localparam logic [7:0] LOAD = 8'(MEM_LATENCY - 1);
    state_t state, state_n;
    logic [7:0] cnt, cnt_n;
    logic drop, drop_n, own_d, own_d_n, lat_we, lat_we_n, ic_acc, dc_acc;
    logic [BLOCK_ADDR_WIDTH-1:0] lat_addr, lat_addr_n;
    logic [BLOCK_WIDTH-1:0] lat_data, lat_data_n;
    assign icache_req_ready = state == IDLE;
    assign dcache_req_ready = state == IDLE && !icache_req_valid;
    assign ic_acc = icache_req_valid && icache_req_ready;
    assign dc_acc = dcache_req_valid && dcache_req_ready;
    assign busy = state != IDLE;
    assign mem_en = state == BUSY && cnt == 8'd1;
    assign mem_we = mem_en && lat_we;
    assign mem_addr = lat_addr;
    assign mem_wdata = lat_data;
    assign icache_resp_valid = state == RESP && !own_d && !drop;
    assign dcache_resp_valid = state == RESP && own_d;
    assign icache_resp_block_data = mem_rdata;
    assign dcache_resp_block_data = mem_rdata;
    always_comb begin
        state_n = state;
        cnt_n = cnt;
        drop_n = drop;
        own_d_n = own_d;
        lat_we_n = lat_we;
        lat_addr_n = lat_addr;
        lat_data_n = lat_data;
        case (state)
            IDLE: if (ic_acc || dc_acc) begin
                state_n = BUSY;
                cnt_n = LOAD;
                own_d_n = !ic_acc;
                lat_we_n = !ic_acc && dcache_req_type;
                lat_addr_n = ic_acc ? icache_req_block_addr : dcache_req_block_addr;
                lat_data_n = ic_acc ? '0 : dcache_req_block_data;
                drop_n = ic_acc && icache_flush;
            end
            BUSY: begin
                cnt_n = cnt - 8'd1;
                state_n = cnt == 8'd1 ? RESP : BUSY;
                drop_n = drop || (icache_flush && !own_d);
            end
            RESP: begin
                state_n = IDLE;
                drop_n = 1'b0;
            end
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt <= '0;
            drop <= 1'b0;
            own_d <= 1'b0;
            lat_we <= 1'b0;
            lat_addr <= '0;
            lat_data <= '0;
        end else begin
            state <= state_n;
            cnt <= cnt_n;
            drop <= drop_n;
            own_d <= own_d_n;
            lat_we <= lat_we_n;
            lat_addr <= lat_addr_n;
            lat_data <= lat_data_n;
        end
    end
endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: scoreboard bench for mem_ctrl at MEM_LATENCY 4 plus a MEM_LATENCY 2 boundary instance
module tb_mem_ctrl;
    localparam int L = 4;
    logic clk = 0, rst = 1;
    always #5 clk = ~clk;
    logic ic_valid = 0, ic_flush = 0, dc_valid = 0, dc_type = 0;
    logic [28:0] ic_addr = 0, dc_addr = 0;
    logic [63:0] dc_data = 0, mem_rdata;
    logic ic_ready, ic_rv, dc_ready, dc_rv, mem_en, mem_we, busy;
    logic [63:0] ic_rd, dc_rd, mem_wdata;
    logic [28:0] mem_addr;
    logic i2_valid = 0;
    logic i2_ready, i2_rv, d2_ready, d2_rv, m2_en, m2_we, busy2;
    logic [63:0] i2_rd, d2_rd, m2_wdata, m2_rdata;
    logic [28:0] m2_addr;
    mem_ctrl #(.MEM_LATENCY(L)) dut (
        .clk(clk), .rst(rst),
        .icache_req_valid(ic_valid), .icache_req_block_addr(ic_addr), .icache_req_ready(ic_ready),
        .icache_flush(ic_flush), .icache_resp_valid(ic_rv), .icache_resp_block_data(ic_rd),
        .dcache_req_valid(dc_valid), .dcache_req_type(dc_type), .dcache_req_block_addr(dc_addr),
        .dcache_req_block_data(dc_data), .dcache_req_ready(dc_ready), .dcache_resp_valid(dc_rv),
        .dcache_resp_block_data(dc_rd), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
    );
    mem_ctrl #(.MEM_LATENCY(2)) dut2 (
        .clk(clk), .rst(rst),
        .icache_req_valid(i2_valid), .icache_req_block_addr(29'h40), .icache_req_ready(i2_ready),
        .icache_flush(1'b0), .icache_resp_valid(i2_rv), .icache_resp_block_data(i2_rd),
        .dcache_req_valid(1'b0), .dcache_req_type(1'b0), .dcache_req_block_addr(29'h0),
        .dcache_req_block_data(64'h0), .dcache_req_ready(d2_ready), .dcache_resp_valid(d2_rv),
        .dcache_resp_block_data(d2_rd), .mem_en(m2_en), .mem_we(m2_we), .mem_addr(m2_addr),
        .mem_wdata(m2_wdata), .mem_rdata(m2_rdata), .busy(busy2)
    );
    int n_tests = 0, n_fail = 0;
    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask
    logic [63:0] mem [logic [28:0]];
    function automatic logic [63:0] rd(input logic [28:0] a);
        return a == 29'h100 ? 64'hDEADBEEF_CAFEF00D : {3'b101, a, 3'b010, ~a};
    endfunction
    function automatic logic [63:0] mem_rd(input logic [28:0] a);
        return mem.exists(a) ? mem[a] : rd(a);
    endfunction
    always @(posedge clk) if (mem_en) begin
        if (mem_we) mem[mem_addr] = mem_wdata;
        mem_rdata <= mem_rd(mem_addr);
    end
    always @(posedge clk) if (m2_en) m2_rdata <= rd(m2_addr);
    typedef struct {int due; bit own_d; bit we; logic [28:0] addr; logic [63:0] data; bit drop;} txn_t;
    txn_t rq[$], mq[$];
    int cyc = 0, ic_acc_cyc = 0, dc_acc_cyc = 0;
    bit ic_acc = 0, dc_acc = 0;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        txn_t t;
        bit idle;
        ic_acc = 0;
        dc_acc = 0;
        if (rst) begin
            rq.delete();
            mq.delete();
        end else begin
            idle = rq.size() == 0;
            chk("busy", 64'(busy), 64'(!idle));
            chk("ic_ready", 64'(ic_ready), 64'(idle));
            chk("dc_ready", 64'(dc_ready), 64'(idle && !ic_valid));
            if (mq.size() != 0 && mq[0].due == cyc) begin
                t = mq.pop_front();
                chk("mem_en", 64'(mem_en), 64'(1));
                chk("mem_we", 64'(mem_we), 64'(t.we));
                chk("mem_addr", 64'(mem_addr), 64'(t.addr));
                if (t.we) chk("mem_wdata", mem_wdata, t.data);
            end else if (mem_en) chk("mem_en_spurious", 64'(mem_en), 64'(0));
            if (rq.size() != 0 && rq[0].due == cyc) begin
                t = rq.pop_front();
                chk("ic_resp_valid", 64'(ic_rv), 64'(!t.own_d && !t.drop));
                chk("dc_resp_valid", 64'(dc_rv), 64'(t.own_d));
                if (!t.own_d && !t.drop) chk("ic_resp_data", ic_rd, t.data);
                if (t.own_d && !t.we) chk("dc_resp_data", dc_rd, t.data);
            end else if (ic_rv || dc_rv) chk("resp_spurious", 64'({ic_rv, dc_rv}), 64'(0));
            if (ic_flush && rq.size() != 0 && !rq[0].own_d) begin
                t = rq[0];
                t.drop = 1;
                rq[0] = t;
            end
            ic_acc = ic_valid && idle;
            dc_acc = !ic_acc && dc_valid && idle;
            if (ic_acc || dc_acc) begin
                t.due = cyc + L;
                t.own_d = dc_acc;
                t.we = dc_acc && dc_type;
                t.addr = dc_acc ? dc_addr : ic_addr;
                t.data = t.we ? dc_data : mem_rd(t.addr);
                t.drop = ic_acc && ic_flush;
                rq.push_back(t);
                t.due = cyc + L - 1;
                mq.push_back(t);
                if (ic_acc) ic_acc_cyc = cyc;
                else dc_acc_cyc = cyc;
            end
        end
    end
    task automatic tick();
        @(posedge clk);
        #1;
        if (ic_acc) ic_valid = 0;
        if (dc_acc) dc_valid = 0;
    endtask
    task automatic wait_idle();
        int n = 0;
        while ((busy || ic_valid || dc_valid) && n < 100) begin
            tick();
            n++;
        end
        chk("idle_timeout", 64'(n < 100), 64'(1));
    endtask
    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end
    initial begin
        int a;
        tick();
        tick();
        rst = 0;
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_mem_en", 64'(mem_en), 64'(0));
        chk("rst_mem_we", 64'(mem_we), 64'(0));
        chk("rst_resp", 64'({ic_rv, dc_rv}), 64'(0));
        chk("rst_ic_ready", 64'(ic_ready), 64'(1));
        chk("rst_dc_ready", 64'(dc_ready), 64'(1));
        ic_addr = 29'h100; ic_valid = 1;
        wait_idle();
        ic_addr = 29'h200; dc_addr = 29'h300; dc_type = 0; ic_valid = 1; dc_valid = 1;
        wait_idle();
        chk("dc_wait_accept", 64'(dc_acc_cyc - ic_acc_cyc), 64'(5));
        dc_addr = 29'h2A; dc_data = 64'h1122334455667788; dc_type = 1; dc_valid = 1;
        wait_idle();
        dc_type = 0; dc_valid = 1;
        wait_idle();
        ic_addr = 29'h100; ic_valid = 1;
        tick();
        a = ic_acc_cyc;
        tick();
        ic_flush = 1;
        tick();
        ic_flush = 0;
        tick();
        ic_addr = 29'h108; ic_valid = 1;
        wait_idle();
        chk("flush_reaccept", 64'(ic_acc_cyc - a), 64'(5));
        ic_addr = 29'h110; ic_valid = 1; ic_flush = 1;
        tick();
        ic_flush = 0;
        wait_idle();
        dc_addr = 29'h55; dc_valid = 1;
        tick();
        ic_flush = 1;
        tick();
        tick();
        ic_flush = 0;
        wait_idle();
        ic_flush = 1;
        tick();
        ic_flush = 0; ic_addr = 29'h77; ic_valid = 1;
        wait_idle();
        ic_addr = 29'h180; ic_valid = 1;
        tick();
        tick();
        rst = 1;
        tick();
        rst = 0;
        chk("mid_rst_busy", 64'(busy), 64'(0));
        tick();
        ic_addr = 29'h188; ic_valid = 1;
        wait_idle();
        repeat (300) begin
            if (!ic_valid && $urandom_range(3) == 0) begin
                ic_valid = 1; ic_addr = 29'($urandom_range(63));
            end
            if (!dc_valid && $urandom_range(3) == 0) begin
                dc_valid = 1; dc_type = 1'($urandom_range(1)); dc_addr = 29'($urandom_range(63));
                dc_data = {$urandom, $urandom};
            end
            ic_flush = $urandom_range(9) == 0;
            tick();
        end
        ic_flush = 0;
        wait_idle();
        i2_valid = 1;
        for (int c = 0; c < 9; c++) begin
            @(negedge clk);
            chk("l2_ready", 64'(i2_ready), 64'(c % 3 == 0));
            chk("l2_mem_en", 64'(m2_en), 64'(c % 3 == 1));
            if (c % 3 == 1) chk("l2_mem_addr", 64'(m2_addr), 64'(29'h40));
            chk("l2_resp", 64'(i2_rv), 64'(c % 3 == 2));
            if (c % 3 == 2) chk("l2_data", i2_rd, rd(29'h40));
            @(posedge clk);
            #1;
        end
        i2_valid = 0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_ctrl.md
MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 Parameter MEM_LATENCY, default 4: cycles from request acceptance to response; legal range 2..255.
REQ-002 Parameter BLOCK_ADDR_WIDTH, default 29: main-memory block address width (32-bit byte address, 8-byte block).
REQ-003 Parameter BLOCK_WIDTH, default 64: block data width in bits.
REQ-004 Clocking: one clock; reset is synchronous and active-high.
REQ-005 clk  input  1  sole clock; all state updates on rising edge.
REQ-006 rst  input  1  synchronous active-high reset.
REQ-007 icache_req_valid  input  1  icache block-read request.
REQ-008 icache_req_block_addr  input  BLOCK_ADDR_WIDTH  icache requested block.
REQ-009 icache_req_ready  output  1  controller accepts icache request.
REQ-010 icache_flush  input  1  fetch redirect; cancels the in-flight icache response.
REQ-011 icache_resp_valid  output  1  one-cycle icache refill strobe.
REQ-012 icache_resp_block_data  output  BLOCK_WIDTH  refill data; valid only with icache_resp_valid.
REQ-013 dcache_req_valid  input  1  dcache request.
REQ-014 dcache_req_type  input  1  0 = read, 1 = write.
REQ-015 dcache_req_block_addr  input  BLOCK_ADDR_WIDTH  dcache block.
REQ-016 dcache_req_block_data  input  BLOCK_WIDTH  write data (writes only).
REQ-017 dcache_req_ready  output  1  controller accepts dcache request.
REQ-018 dcache_resp_valid  output  1  one-cycle strobe: read data, or write acknowledge.
REQ-019 dcache_resp_block_data  output  BLOCK_WIDTH  read data; don't-care on write acknowledge.
REQ-020 mem_en  output  1  main-memory access strobe.
REQ-021 mem_we  output  1  main-memory write enable; qualified by mem_en.
REQ-022 mem_addr  output  BLOCK_ADDR_WIDTH  main-memory block address.
REQ-023 mem_wdata  output  BLOCK_WIDTH  main-memory write data.
REQ-024 mem_rdata  input  BLOCK_WIDTH  main-memory read data, valid the cycle after mem_en.
REQ-025 busy  output  1  high whenever state is not IDLE.

Function
REQ-026 FSM states: IDLE, BUSY, RESP; exactly one transaction in flight.
REQ-027 icache_req_ready = (state == IDLE); dcache_req_ready = (state == IDLE) && !icache_req_valid; both outputs are combinational.
REQ-028 Acceptance: a port's request is accepted in the cycle where its valid and ready are both high. Accepting latches owner (I/D), type (icache always read), address, and write data, and moves the FSM IDLE->BUSY.
REQ-029 Priority: icache wins simultaneous requests; the dcache request stays pending unaccepted and may hold valid.
REQ-030 Latency counter: loaded with MEM_LATENCY-1 on acceptance; decrements each BUSY cycle.
REQ-031 Memory access: mem_en is high for exactly one cycle, when the counter equals 1. In that cycle mem_addr and mem_we come from the latched fields, and mem_wdata = latched data on writes.
REQ-032 BUSY->RESP when the counter reaches 0.
REQ-033 RESP lasts exactly one cycle, then RESP->IDLE.
REQ-034 Response timing: for a request accepted in cycle T, the response strobe is high in cycle T+MEM_LATENCY only. Resp data = mem_rdata passthrough in that cycle.
REQ-035 Throughput: the earliest next acceptance is cycle T+MEM_LATENCY+1.
REQ-036 Flush, setting: icache_flush high while owner = icache and state is BUSY or RESP sets a drop flag. Flush in the acceptance cycle of an icache request also sets it.
REQ-037 Flush, effect: when the drop flag is set, icache_resp_valid is suppressed for that transaction. Memory timing and the return to IDLE are unchanged; the drop flag clears on RESP->IDLE.
REQ-038 icache_flush has no effect when idle with no icache acceptance, and no effect on dcache transactions.
REQ-039 Outputs are independent of new requests while not IDLE; latched fields are not modified mid-transaction.
REQ-040 Invariants: mem_en is never high outside BUSY; icache_resp_valid and dcache_resp_valid are never high together.

Reset
REQ-041 Reset takes effect on the first rising edge with rst high; it wins over every other input that cycle.
REQ-042 Reset values:
- state IDLE; counter, drop flag, owner, and latched type/address/data all 0.
- mem_en, mem_we, icache_resp_valid, dcache_resp_valid, busy all 0.
- icache_req_ready = 1 and dcache_req_ready = !icache_req_valid once rst deasserts.
REQ-043 Reset mid-transaction abandons it: no mem_en and no response strobe follow.

Verification
REQ-044 MEM_LATENCY=4; icache read of addr 0x100 accepted at cycle 0 -> mem_en=1, mem_we=0, mem_addr=0x100 at cycle 3; icache_resp_valid=1 at cycle 4 with data = mem_rdata (0xDEADBEEF_CAFEF00D); icache_req_ready=1 again at cycle 5.
REQ-045 Both ports valid at cycle 0 -> icache accepted and dcache_req_ready=0. The dcache request, held valid, is accepted at cycle 5 and dcache_resp_valid=1 at cycle 9.
REQ-046 dcache write to 0x2A with data 0x1122334455667788 at cycle 0 -> cycle 3 mem_en=1, mem_we=1, mem_wdata matches; dcache_resp_valid=1 at cycle 4; icache_resp_valid stays 0.
REQ-047 icache request at cycle 0, icache_flush=1 at cycle 2 -> mem_en still at cycle 3; icache_resp_valid=0 at cycle 4; new icache request accepted at cycle 5 responds normally at cycle 9.
REQ-048 Request accepted at cycle 0, rst=1 at cycle 2 -> from cycle 3: busy=0, no mem_en, no response strobe; a request at cycle 4 is accepted and responds at cycle 8.
REQ-049 MEM_LATENCY=2 boundary: request at cycle 0 -> mem_en at cycle 1, response at cycle 2; back-to-back icache requests are accepted at cycles 0, 3, 6.
